// File: rtl/ps2_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, command and
// reply byte constants, and the frame builder used when a byte is accepted.
package ps2_tx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] RESP_ACK     = 8'hFA;
    localparam logic [7:0] RESP_BAT_OK  = 8'hAA;

    localparam int FRAME_BITS = 10;

    // {stop, odd parity, data}; shifted out LSB first after the start bit.
    function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises an open-drain PS/2 line and accepts a level change only after
// FILTER_LEN consecutive equal samples; fall_tick marks each accepted 1->0.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_filt,
    output logic fall_tick
);

    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic [FW-1:0] run_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            run_cnt   <= '0;
            line_filt <= 1'b1;
            fall_tick <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], line_in};
            fall_tick <= 1'b0;
            if (sync_q[1] == line_filt) begin
                run_cnt <= '0;
            end else if (run_cnt == FW'(FILTER_LEN - 1)) begin
                // this sample completes the run of differing samples
                run_cnt   <= '0;
                line_filt <= sync_q[1];
                fall_tick <= line_filt;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one command frame on device clock falls and checks the device ACK.
module ps2_tx
    import ps2_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 65_000_000,
    parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10_000,
    parameter int TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1_000) * 15,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout,
    output logic       bus_owned,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CW = $clog2(max_int(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);

    ps2_state_e            state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [3:0]            bit_cnt, bit_cnt_n;
    logic [FRAME_BITS-1:0] frame, frame_n;
    logic                  ack_ok, ack_ok_n;
    logic                  clk_oe_n, data_oe_n;
    logic                  done_n, err_n, to_n;
    logic                  clk_filt, fall_tick;
    logic [1:0]            data_sync;
    logic                  data_s, timed_out;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk       (clk),
        .rst_n     (reset_n),
        .line_in   (ps2_clk_in),
        .line_filt (clk_filt),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) data_sync <= 2'b11;
        else          data_sync <= {data_sync[0], ps2_data_in};
    end
    assign data_s    = data_sync[1];
    assign timed_out = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            frame       <= '0;
            ack_ok      <= 1'b0;
            tx_ready    <= 1'b1;
            bus_owned   <= 1'b0;
            tx_done     <= 1'b0;
            tx_ack_err  <= 1'b0;
            tx_timeout  <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_cnt     <= bit_cnt_n;
            frame       <= frame_n;
            ack_ok      <= ack_ok_n;
            // ready lags the status pulse by one cycle when returning to IDLE
            tx_ready    <= (state == IDLE) && (state_n == IDLE);
            bus_owned   <= (state_n != IDLE);
            tx_done     <= done_n;
            tx_ack_err  <= err_n;
            tx_timeout  <= to_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        frame_n   = frame;
        ack_ok_n  = ack_ok;
        clk_oe_n  = ps2_clk_oe;
        data_oe_n = ps2_data_oe;
        done_n    = 1'b0;
        err_n     = 1'b0;
        to_n      = 1'b0;
        case (state)
            IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (tx_valid && tx_ready) begin
                    frame_n   = ps2_frame(tx_data);
                    bit_cnt_n = '0;
                    cnt_n     = '0;
                    ack_ok_n  = 1'b0;
                    clk_oe_n  = 1'b1;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                clk_oe_n  = 1'b1;
                data_oe_n = 1'b0;
                if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_n     = '0;
                    data_oe_n = 1'b1;
                    state_n   = REQ;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            REQ: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b1;
                cnt_n     = '0;
                state_n   = SEND;
            end
            SEND: begin
                clk_oe_n = 1'b0;
                if (fall_tick) begin
                    data_oe_n = ~frame[bit_cnt];
                    bit_cnt_n = bit_cnt + 1'b1;
                    cnt_n     = '0;
                    if (bit_cnt == 4'd9) state_n = ACK;
                end else if (timed_out) begin
                    data_oe_n = 1'b0;
                    to_n      = 1'b1;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ACK: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (fall_tick) begin
                    cnt_n    = '0;
                    ack_ok_n = ~data_s;
                    err_n    = data_s;
                    state_n  = WAIT_IDLE;
                end else if (timed_out) begin
                    to_n    = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (clk_filt && data_s) begin
                    done_n  = ack_ok;
                    state_n = IDLE;
                end else if (fall_tick) begin
                    cnt_n = '0;
                end else if (timed_out) begin
                    // a NACK already reported this transfer; keep pulses exclusive
                    to_n    = ack_ok;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                state_n   = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model clocks frames out of the host over a
// wired-AND bus, and a frame model built from the byte checks every bit.
module tb_ps2_tx;

    localparam int INH   = 60;
    localparam int TMO   = 1500;
    localparam int FLEN  = 4;
    localparam int HALF  = 40;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_ack_err, tx_timeout, bus_owned;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;
    wire        ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    wire        ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_tx #(
        .CLK_FREQ_HZ(65_000_000), .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLEN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_ack_err(tx_ack_err),
        .tx_timeout(tx_timeout), .bus_owned(bus_owned),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp, n_bad;
    int n_done, n_err, n_to, n_start, n_pulse_ready;
    logic prev_owned = 1'b0;

    always @(negedge clk) begin
        if (tx_done)    n_done++;
        if (tx_ack_err) n_err++;
        if (tx_timeout) n_to++;
        if ((tx_done || tx_ack_err || tx_timeout) && tx_ready) n_pulse_ready++;
        if (bus_owned && !prev_owned) n_start++;
        prev_owned = bus_owned;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame the device should receive: data LSB first, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        logic [9:0] f;
        for (int i = 0; i < 8; i++) f[i] = d[i];
        f[8] = ($countones(d) % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic wait_ready(input string tag);
        int w = 0;
        while (!tx_ready && w < 4000) begin @(negedge clk); w++; end
        chk({tag, "_ready"}, 32'(tx_ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device model: measure inhibit, check start bit, clock 11 falls.
    task automatic bfm_rx(input bit ack, input bit do_reset, input bit inject,
                          output logic [9:0] bits, output int inh, output bit owned_ok);
        int w = 0;
        bits = '0; inh = 0; owned_ok = 1'b1;
        while (!ps2_clk_oe && w < 200) begin @(negedge clk); w++; end
        if (!ps2_clk_oe) begin chk("inhibit_seen", 32'd0, 32'd1); return; end
        while (ps2_clk_oe && inh < 20000) begin @(negedge clk); inh++; end
        chk("start_bit", 32'(ps2_data_in), 32'd0);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_data = ack ? 1'b0 : 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            if (inject && k == 2) begin tx_data = 8'hFF; tx_valid = 1'b1; end
            if (inject && k == 5) tx_valid = 1'b0;
            repeat (HALF) @(negedge clk);
            if (do_reset && k == 5) begin
                chk("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
                #2 reset_n = 1'b0;
                #1;
                chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
                chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
                @(negedge clk);
                dev_clk = 1'b1; dev_data = 1'b1;
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            dev_clk = 1'b1;
            if (k <= 10) bits[k-1] = ps2_data_in;
            if (!bus_owned) owned_ok = 1'b0;
        end
        repeat (4) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic run_xfer(input string tag, input logic [7:0] d, input bit ack,
                            input bit inject, input bit exp_par,
                            input int exp_done, input int exp_err);
        int d0, e0, t0, s0, inh;
        logic [9:0] bits;
        bit own;
        d0 = n_done; e0 = n_err; t0 = n_to; s0 = n_start;
        send_byte(d);
        bfm_rx(ack, 1'b0, inject, bits, inh, own);
        wait_ready(tag);
        repeat (inject ? 300 : 3) @(negedge clk);
        chk({tag, "_frame"}, 32'(bits), 32'(model_frame(d)));
        chk({tag, "_parity"}, 32'(bits[8]), 32'(exp_par));
        chk({tag, "_inhibit_ge"}, 32'(inh >= INH), 32'd1);
        chk({tag, "_owned"}, 32'(own), 32'd1);
        chk({tag, "_done"}, 32'(n_done - d0), 32'(exp_done));
        chk({tag, "_ackerr"}, 32'(n_err - e0), 32'(exp_err));
        chk({tag, "_timeout"}, 32'(n_to - t0), 32'd0);
        chk({tag, "_starts"}, 32'(n_start - s0), 32'd1);
        chk({tag, "_ready_after"}, 32'(tx_ready), 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int d0, e0, t0, c, w;
        logic [9:0] bits;
        int inh;
        bit own;

        reset_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
        dev_clk = 1'b1; dev_data = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_owned", 32'(bus_owned), 32'd0);
        chk("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("rst_pulses", 32'({tx_done, tx_ack_err, tx_timeout}), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        vecs.push_back('{8'hED, 1'b1, 1'b1, 1, 0});
        vecs.push_back('{8'h00, 1'b1, 1'b1, 1, 0});
        vecs.push_back('{8'h01, 1'b1, 1'b0, 1, 0});
        vecs.push_back('{8'hED, 1'b0, 1'b1, 0, 1});
        vecs.push_back('{8'h80, 1'b1, 1'b0, 1, 0});
        vecs.push_back('{8'hFA, 1'b1, 1'b1, 1, 0});
        for (int i = 0; i < 6; i++) begin
            logic [7:0] r;
            bit a;
            r = 8'($urandom_range(0, 255));
            a = 1'($urandom_range(0, 1));
            vecs.push_back('{r, a, ($countones(r) % 2 == 0), int'(a), int'(!a)});
        end
        for (int i = 0; i < vecs.size(); i++)
            run_xfer($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack, 1'b0,
                     vecs[i].exp_par, vecs[i].exp_done, vecs[i].exp_err);

        // device never clocks: timeout counted from first SEND cycle
        d0 = n_done; e0 = n_err; t0 = n_to;
        send_byte(8'h5A);
        w = 0;
        while (!ps2_clk_oe && w < 200) begin @(negedge clk); w++; end
        while (ps2_clk_oe && w < 1000) begin @(negedge clk); w++; end
        c = 0;
        while (!tx_timeout && c < TMO + 200) begin @(negedge clk); c++; end
        chk("tmo_latency", 32'(c), 32'(TMO));
        chk("tmo_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        repeat (3) @(negedge clk);
        chk("tmo_pulse", 32'(n_to - t0), 32'd1);
        chk("tmo_no_other", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        chk("tmo_ready", 32'(tx_ready), 32'd1);

        // 0xFF offered mid-frame must be ignored
        run_xfer("inject", 8'hED, 1'b1, 1'b1, 1'b1, 1, 0);

        // reset during bit 4, then a clean send
        d0 = n_done; e0 = n_err; t0 = n_to;
        send_byte(8'hEE);
        bfm_rx(1'b1, 1'b1, 1'b0, bits, inh, own);
        repeat (5) @(negedge clk);
        chk("rst_mid_pulses", 32'((n_done - d0) + (n_err - e0) + (n_to - t0)), 32'd0);
        chk("rst_mid_ready", 32'(tx_ready), 32'd1);
        run_xfer("after_rst", 8'hEE, 1'b1, 1'b0, 1'b1, 1, 0);

        chk("pulse_vs_ready", 32'(n_pulse_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
